goldschmidt_ctrl: RTL

//   Sequencing controller for the Goldschmidt divider datapath. Accepts a divide request, then drives
//   the datapath controls cycle by cycle: k_select, nd_select, n_enable, d_enable and ld_operands.

---
 rtl/goldschmidt_pkg.sv | 32 +++
 rtl/goldschmidt_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/goldschmidt_pkg.sv
// ============================================================================
// Module   : goldschmidt_pkg
// Purpose  : State encoding and datapath mux select codes shared by the
//            Goldschmidt controller and the datapath it drives.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package goldschmidt_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_INIT_D = 3'd2,
    S_INIT_N = 3'd3,
    S_ITER_N = 3'd4,
    S_ITER_D = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  // Operand mux codes: raw operands first, fed-back registers second.
  localparam logic [1:0] ND_SEL_D  = 2'd0;
  localparam logic [1:0] ND_SEL_N  = 2'd1;
  localparam logic [1:0] ND_SEL_FD = 2'd2;
  localparam logic [1:0] ND_SEL_FN = 2'd3;

  localparam logic K_SEL_IA = 1'b0;
  localparam logic K_SEL_FB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/goldschmidt_ctrl.sv
// ============================================================================
// Module   : goldschmidt_ctrl
// Purpose  : Sequencer for the Goldschmidt divider: one IA scaling pass,
//            ITERS refinement passes, then a done/ack handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module goldschmidt_ctrl
  import goldschmidt_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          d_zero,
  input  logic          ack,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          div_err,
  output logic          ld_operands,
  output logic          k_select,
  output logic [1:0]    nd_select,
  output logic          n_enable,
  output logic          d_enable,
  output logic [CW-1:0] iter_count
);

  generate
    if (ITERS < 0 || ITERS > 15 || (2 ** CW) <= ITERS) begin : g_bad_params
      $error("goldschmidt_ctrl: ITERS must be 0..15 and fit in CW bits");
    end
  endgenerate

  localparam logic [CW-1:0] ITERS_C = CW'(ITERS);
  localparam logic [CW-1:0] LAST_C  = CW'(ITERS - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e        state_q, state_d;
  logic          div_err_q, div_err_d;
  logic [CW-1:0] iter_count_q, iter_count_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      div_err_q    <= 1'b0;
      iter_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_err_q    <= div_err_d;
      iter_count_q <= iter_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_err_d    = div_err_q;
    iter_count_d = iter_count_q;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    ld_operands  = 1'b0;
    k_select     = K_SEL_IA;
    nd_select    = ND_SEL_D;
    n_enable     = 1'b0;
    d_enable     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d   = S_LOAD;
          div_err_d = 1'b0;
        end
      end
      S_LOAD: begin
        busy        = 1'b1;
        ld_operands = 1'b1;
        div_err_d   = d_zero;
        state_d     = d_zero ? S_DONE : S_INIT_D;
      end
      S_INIT_D: begin
        busy      = 1'b1;
        k_select  = K_SEL_IA;
        nd_select = ND_SEL_D;
        d_enable  = 1'b1;
        state_d   = S_INIT_N;
      end
      S_INIT_N: begin
        busy         = 1'b1;
        k_select     = K_SEL_IA;
        nd_select    = ND_SEL_N;
        n_enable     = 1'b1;
        iter_count_d = '0;
        state_d      = (ITERS > 0) ? S_ITER_N : S_DONE;
      end
      // N is refined before D so both passes see the same K = 2 - D.
      S_ITER_N: begin
        busy      = 1'b1;
        k_select  = K_SEL_FB;
        nd_select = ND_SEL_FN;
        n_enable  = 1'b1;
        state_d   = S_ITER_D;
      end
      S_ITER_D: begin
        busy      = 1'b1;
        k_select  = K_SEL_FB;
        nd_select = ND_SEL_FD;
        d_enable  = 1'b1;
        if (iter_count_q != ITERS_C) begin
          iter_count_d = iter_count_q + ONE_C;
        end
        state_d = (iter_count_q == LAST_C) ? S_DONE : S_ITER_N;
      end
      S_DONE: begin
        done = 1'b1;
        if (ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign div_err    = div_err_q;
  assign iter_count = iter_count_q;

endmodule

`default_nettype wire
